// File: rtl/sc_ifu.sv
// sc_ifu: PC register and fetch/execute sequencer for the single-cycle MIPS core.
// Fetches each word over a req/ack handshake, holds it for one execute window, then commits npc.
module sc_ifu #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  pcsrc,
  input  logic [31:0] ra,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  output logic [31:0] pc,
  output logic [31:0] pc4,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic [31:0] retired,
  output logic        fault
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t      state_r;
  logic [31:0] pc_r;
  logic [31:0] inst_r;
  logic [31:0] retired_r;
  logic        fault_r;

  logic [31:0] pc4_s;
  logic [31:0] npc_s;

  function automatic logic [31:0] branch_target(input logic [31:0] seq_pc, input logic [15:0] imm);
    return seq_pc + {{14{imm[15]}}, imm, 2'b00};
  endfunction

  function automatic logic [31:0] jump_target(input logic [31:0] seq_pc, input logic [25:0] idx);
    return {seq_pc[31:28], idx, 2'b00};
  endfunction

  // Sequential PC and next-PC selection; ra passes through unmodified so jr can fault.
  always_comb begin
    pc4_s = pc_r + 32'd4;
    npc_s = pc4_s;
    case (pcsrc)
      2'b00:   npc_s = pc4_s;
      2'b01:   npc_s = branch_target(pc4_s, inst_r[15:0]);
      2'b10:   npc_s = ra;
      2'b11:   npc_s = jump_target(pc4_s, inst_r[25:0]);
      default: npc_s = pc4_s;
    endcase
  end

  // Fetch/execute/halt sequencer; HALT is left only through reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= FETCH;
      pc_r      <= RESET_PC;
      inst_r    <= 32'd0;
      retired_r <= 32'd0;
      fault_r   <= 1'b0;
    end else begin
      case (state_r)
        FETCH: begin
          if (imem_ack) begin
            inst_r  <= imem_rdata;
            state_r <= EXEC;
          end
        end
        EXEC: begin
          if (!stall) begin
            if (npc_s[1:0] != 2'b00) begin
              fault_r <= 1'b1;
              state_r <= HALT;
            end else begin
              pc_r      <= npc_s;
              retired_r <= retired_r + 32'd1;
              state_r   <= FETCH;
            end
          end
        end
        HALT: begin
          state_r <= HALT;
        end
        default: begin
          state_r <= HALT;
          fault_r <= 1'b1;
        end
      endcase
    end
  end

  assign imem_req   = (state_r == FETCH);
  assign imem_addr  = pc_r;
  assign inst_valid = (state_r == EXEC);
  assign pc         = pc_r;
  assign pc4        = pc4_s;
  assign inst       = inst_r;
  assign retired    = retired_r;
  assign fault      = fault_r;

endmodule

// File: tb/tb_sc_ifu.sv
// Bench for sc_ifu: directed scenarios plus a random run, checked every cycle against a
// transaction-level model of the fetch/execute rules.
module tb_sc_ifu;

  logic        clk;
  logic        reset;
  logic [1:0]  pcsrc;
  logic [31:0] ra;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ack;
  logic [31:0] pc;
  logic [31:0] pc4;
  logic [31:0] inst;
  logic        inst_valid;
  logic [31:0] retired;
  logic        fault;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int PH_FETCH = 0;
  localparam int PH_EXEC  = 1;
  localparam int PH_HALT  = 2;

  // Reference model state
  int          m_phase;
  logic [31:0] m_pc;
  logic [31:0] m_inst;
  logic [31:0] m_ret;
  logic        m_fault;

  sc_ifu #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .reset(reset), .pcsrc(pcsrc), .ra(ra), .stall(stall),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .imem_ack(imem_ack), .pc(pc), .pc4(pc4), .inst(inst),
    .inst_valid(inst_valid), .retired(retired), .fault(fault)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Target address the control unit asks for, derived from MIPS semantics.
  function automatic logic [31:0] model_target(input logic [31:0] cur_pc, input logic [31:0] iw,
                                               input logic [1:0] sel, input logic [31:0] rav);
    logic [31:0] seq;
    int signed   off;
    seq = cur_pc + 32'd4;
    off = int'($signed(iw[15:0])) * 4;
    case (sel)
      2'b01:   return seq + 32'(off);
      2'b10:   return rav;
      2'b11:   return (seq & 32'hF000_0000) | ((iw & 32'h03FF_FFFF) * 32'd4);
      default: return seq;
    endcase
  endfunction

  task automatic check_outputs();
    chk("imem_req",   32'(imem_req),   32'(m_phase == PH_FETCH));
    chk("imem_addr",  imem_addr,       m_pc);
    chk("pc",         pc,              m_pc);
    chk("pc4",        pc4,             m_pc + 32'd4);
    chk("inst",       inst,            m_inst);
    chk("inst_valid", 32'(inst_valid), 32'(m_phase == PH_EXEC));
    chk("retired",    retired,         m_ret);
    chk("fault",      32'(fault),      32'(m_fault));
  endtask

  // One clock: advance the model with the inputs currently driven, then compare.
  task automatic tick();
    logic [31:0] tgt;
    if (reset) begin
      m_phase = PH_FETCH; m_pc = RST_PC; m_inst = 32'd0; m_ret = 32'd0; m_fault = 1'b0;
    end else if (m_phase == PH_FETCH) begin
      if (imem_ack) begin
        m_inst  = imem_rdata;
        m_phase = PH_EXEC;
      end
    end else if (m_phase == PH_EXEC && !stall) begin
      tgt = model_target(m_pc, m_inst, pcsrc, ra);
      if (tgt % 4 != 0) begin
        m_fault = 1'b1;
        m_phase = PH_HALT;
      end else begin
        m_pc    = tgt;
        m_ret   = m_ret + 32'd1;
        m_phase = PH_FETCH;
      end
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic do_fetch(input int wait_cycles, input logic [31:0] word);
    imem_ack = 1'b0;
    for (int i = 0; i < wait_cycles; i++) tick();
    imem_ack = 1'b1;
    imem_rdata = word;
    tick();
    imem_ack = 1'b0;
    imem_rdata = $urandom;
  endtask

  task automatic do_exec(input int stall_cycles, input logic [1:0] sel, input logic [31:0] rav);
    stall = 1'b1;
    pcsrc = 2'($urandom_range(3, 0));
    ra    = $urandom;
    for (int i = 0; i < stall_cycles; i++) tick();
    stall = 1'b0;
    pcsrc = sel;
    ra    = rav;
    tick();
    pcsrc = 2'b00;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    logic [31:0] snap_pc;
    reset = 1'b1; pcsrc = 2'b00; ra = 32'd0; stall = 1'b0;
    imem_ack = 1'b0; imem_rdata = 32'd0;
    m_phase = PH_FETCH; m_pc = RST_PC; m_inst = 32'd0; m_ret = 32'd0; m_fault = 1'b0;

    // Reset values
    tick();
    chk("rst_req", 32'(imem_req), 32'd1);
    chk("rst_valid", 32'(inst_valid), 32'd0);
    reset = 1'b0;

    // Three sequential instructions, ack in the request cycle
    chk("seq_addr0", imem_addr, 32'h0);
    do_fetch(0, 32'h2000_0001);
    do_exec(0, 2'b00, 32'd0);
    chk("seq_addr1", imem_addr, 32'h4);
    do_fetch(0, 32'h2000_0002);
    do_exec(0, 2'b00, 32'd0);
    chk("seq_addr2", imem_addr, 32'h8);
    do_fetch(0, 32'h2000_0003);
    do_exec(0, 2'b00, 32'd0);
    chk("seq_retired", retired, 32'd3);

    // Branch to itself: imm = -1 at 0x100
    do_fetch(0, 32'h0000_0008);
    do_exec(0, 2'b10, 32'h0000_0100);
    do_fetch(0, 32'h1000_FFFF);
    do_exec(0, 2'b01, 32'd0);
    chk("branch_self", imem_addr, 32'h0000_0100);

    // Jump crossing a 256 MB region
    do_fetch(0, 32'h0000_0008);
    do_exec(0, 2'b10, 32'h3FFF_FFFC);
    do_fetch(0, 32'h0800_0010);
    do_exec(0, 2'b11, 32'd0);
    chk("jump_region", pc, 32'h4000_0040);

    // Slow memory and stalls: 3 wait + 1 ack + 2 stall + 1 commit
    snap_pc = pc;
    do_fetch(3, 32'h2000_0004);
    chk("slow_inst", inst, 32'h2000_0004);
    do_exec(2, 2'b00, 32'd0);
    chk("slow_pc", pc, snap_pc + 32'd4);

    // jr to aligned, then misaligned target
    do_fetch(1, 32'h0000_0008);
    do_exec(0, 2'b10, 32'h0040_0000);
    chk("jr_ok", pc, 32'h0040_0000);
    do_fetch(0, 32'h0000_0008);
    do_exec(1, 2'b10, 32'h0040_0002);
    chk("jr_fault", 32'(fault), 32'd1);
    chk("jr_halt_pc", pc, 32'h0040_0000);
    for (int i = 0; i < 6; i++) begin
      imem_ack = 1'(i % 2); stall = 1'(i / 2 % 2); imem_rdata = $urandom;
      tick();
    end
    imem_ack = 1'b0; stall = 1'b0;

    // Reset out of HALT, during FETCH, and during a stalled EXEC
    do_reset();
    chk("halt_exit_fault", 32'(fault), 32'd0);
    do_fetch(2, 32'h2000_0005);
    do_exec(0, 2'b00, 32'd0);
    imem_ack = 1'b0;
    tick();
    do_reset();
    chk("rst_fetch_pc", pc, RST_PC);
    do_fetch(0, 32'h2000_0006);
    stall = 1'b1;
    tick();
    do_reset();
    stall = 1'b0;
    chk("rst_exec_ret", retired, 32'd0);
    chk("rst_exec_req", 32'(imem_req), 32'd1);

    // Retired counter wrap
    do_fetch(0, 32'h2000_0007);
    force dut.retired_r = 32'hFFFF_FFFF;
    #1;
    release dut.retired_r;
    m_ret = 32'hFFFF_FFFF;
    do_exec(0, 2'b00, 32'd0);
    chk("ret_wrap", retired, 32'd0);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      reset      = (m_phase == PH_HALT) ? 1'($urandom_range(2, 0) == 0) : 1'($urandom_range(99, 0) == 0);
      imem_ack   = 1'($urandom_range(2, 0) == 0);
      imem_rdata = $urandom;
      stall      = 1'($urandom_range(3, 0) == 0);
      pcsrc      = 2'($urandom_range(3, 0));
      ra         = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(19, 0) == 0) ra[1:0] = 2'($urandom_range(3, 1));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
